// File: rtl/seven_segment_decoder.sv
// Recovers hex nibbles from a scanned seven-segment bus once each digit's pattern is stable.
// Optional decimal-point capture is enabled with `define SEVEN_SEGMENT_DECODER_DP_EN.
module seven_segment_decoder #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET,
  input  logic [6:0]              i_SEVEN_SEGMENT_NUMBER,
  input  logic                    i_COMMON_ANOD,
  input  logic [N_DIGITS-1:0]     i_DIGIT_ENABLE,
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
  input  logic                    i_DECIMAL_POINT,
  output logic [N_DIGITS-1:0]     o_DP_FLAGS,
`endif
  output logic [4*N_DIGITS-1:0]   o_FOUR_BIT_NUMBERS,
  output logic [N_DIGITS-1:0]     o_DIGIT_VALID,
  output logic                    o_UPDATE,
  output logic                    o_ERROR
);

  localparam int IDXW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW   = IDXW + 8;

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_e;

  logic [6:0]            lit;
  logic                  dpLit;
  logic [IDXW-1:0]       enIdx;
  logic                  sampleValid;
  logic                  isNew;
  logic                  commitNow;
  logic [SW-1:0]         curSample;
  logic [3:0]            decNib;
  logic                  decHit;
  logic                  decBlank;

  state_e                state_q;
  logic [7:0]            runCount_q;
  logic [SW-1:0]         sample_q;
  logic [4*N_DIGITS-1:0] nibbles_q;
  logic [N_DIGITS-1:0]   digitValid_q;
  logic                  update_q;
  logic                  error_q;

  assign lit = i_COMMON_ANOD ? ~i_SEVEN_SEGMENT_NUMBER : i_SEVEN_SEGMENT_NUMBER;

`ifdef SEVEN_SEGMENT_DECODER_DP_EN
  logic [N_DIGITS-1:0]   dpFlags_q;
  assign dpLit      = i_COMMON_ANOD ? ~i_DECIMAL_POINT : i_DECIMAL_POINT;
  assign o_DP_FLAGS = dpFlags_q;
`else
  assign dpLit = 1'b0;
`endif

  assign sampleValid = ($countones(i_DIGIT_ENABLE) == 1);

  always_comb begin
    enIdx = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (i_DIGIT_ENABLE[k]) enIdx = IDXW'(k);
    end
  end

  assign curSample = {enIdx, dpLit, lit};
  assign isNew     = (state_q == IDLE) || (curSample != sample_q);
  // A repeat in TRACK commits when it would bring the run up to STABLE_CYCLES.
  assign commitNow = sampleValid &&
                     (isNew ? (STABLE_CYCLES == 1)
                            : ((state_q == TRACK) && (runCount_q == 8'(STABLE_CYCLES - 1))));

  always_comb begin
    decHit = 1'b1;
    decNib = 4'h0;
    case (lit)
      7'h3F: decNib = 4'h0;
      7'h06: decNib = 4'h1;
      7'h5B: decNib = 4'h2;
      7'h4F: decNib = 4'h3;
      7'h66: decNib = 4'h4;
      7'h6D: decNib = 4'h5;
      7'h7D: decNib = 4'h6;
      7'h07: decNib = 4'h7;
      7'h7F: decNib = 4'h8;
      7'h6F: decNib = 4'h9;
      7'h77: decNib = 4'hA;
      7'h7C: decNib = 4'hB;
      7'h39: decNib = 4'hC;
      7'h5E: decNib = 4'hD;
      7'h79: decNib = 4'hE;
      7'h71: decNib = 4'hF;
      default: decHit = 1'b0;
    endcase
  end

  assign decBlank = (lit == 7'h00);

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q      <= IDLE;
      runCount_q   <= 8'd0;
      sample_q     <= '0;
      nibbles_q    <= '0;
      digitValid_q <= '0;
      update_q     <= 1'b0;
      error_q      <= 1'b0;
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
      dpFlags_q    <= '0;
`endif
    end else begin
      update_q <= 1'b0;
      error_q  <= 1'b0;
      if (!sampleValid) begin
        state_q    <= IDLE;
        runCount_q <= 8'd0;
      end else if (isNew) begin
        sample_q   <= curSample;
        runCount_q <= 8'd1;
        state_q    <= (STABLE_CYCLES == 1) ? HELD : TRACK;
      end else if (state_q == TRACK) begin
        runCount_q <= runCount_q + 8'd1;
        if (commitNow) state_q <= HELD;
      end
      // Blank and illegal patterns both invalidate the digit but keep its last nibble.
      if (commitNow) begin
        if (decHit) begin
          nibbles_q[4*int'(enIdx) +: 4] <= decNib;
          digitValid_q[enIdx]           <= 1'b1;
          update_q                      <= 1'b1;
        end else begin
          digitValid_q[enIdx] <= 1'b0;
          error_q             <= !decBlank;
        end
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
        dpFlags_q[enIdx] <= dpLit;
`endif
      end
    end
  end

  assign o_FOUR_BIT_NUMBERS = nibbles_q;
  assign o_DIGIT_VALID      = digitValid_q;
  assign o_UPDATE           = update_q;
  assign o_ERROR            = error_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Randomized bench for seven_segment_decoder against a run-length reference model.
// Also covers SEVEN_SEGMENT_DECODER_DP_EN when that macro is defined.
module tb_seven_segment_decoder;

  localparam int N = 4;
  localparam int S = 4;
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [6:0]     seg;
  logic           anode;
  logic [N-1:0]   en;
  logic [4*N-1:0] nibblesOut;
  logic [N-1:0]   validOut;
  logic           updateOut;
  logic           errorOut;
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
  logic           dpIn;
  logic [N-1:0]   dpFlagsOut;
`endif

  int checks = 0;
  int errors = 0;
  int updSeen = 0;
  int errSeen = 0;

  // Reference model state: per-digit results plus the current run of identical samples.
  logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] expNib [N];
  bit         expValid [N];
  bit         expDp [N];
  bit         expUpd, expErr;
  int         runLen;
  int         prevIdx;
  logic [6:0] prevLit;
  bit         prevDp;

  seven_segment_decoder #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .i_CLK                  (clk),
    .i_RESET                (rst),
    .i_SEVEN_SEGMENT_NUMBER (seg),
    .i_COMMON_ANOD          (anode),
    .i_DIGIT_ENABLE         (en),
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
    .i_DECIMAL_POINT        (dpIn),
    .o_DP_FLAGS             (dpFlagsOut),
`endif
    .o_FOUR_BIT_NUMBERS     (nibblesOut),
    .o_DIGIT_VALID          (validOut),
    .o_UPDATE               (updateOut),
    .o_ERROR                (errorOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [4*N-1:0] packNibbles();
    logic [4*N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[4*k +: 4] = expNib[k];
    return v;
  endfunction

  function automatic logic [N-1:0] packValid();
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = expValid[k];
    return v;
  endfunction

  function automatic logic [N-1:0] packDp();
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = expDp[k];
    return v;
  endfunction

  task automatic modelEdge(input logic [6:0] litIn, input logic [N-1:0] enIn, input bit rstIn, input bit dpLitIn);
    int  idx;
    int  val;
    bit  dpS;
    expUpd = 1'b0;
    expErr = 1'b0;
    if (rstIn) begin
      for (int k = 0; k < N; k++) begin
        expNib[k] = 4'h0; expValid[k] = 1'b0; expDp[k] = 1'b0;
      end
      runLen = 0;
      return;
    end
    if ($countones(enIn) != 1) begin
      runLen = 0;
      return;
    end
    idx = 0;
    for (int k = 0; k < N; k++) if (enIn[k]) idx = k;
    dpS = DP_EN ? dpLitIn : 1'b0;
    if (runLen == 0 || idx != prevIdx || litIn != prevLit || dpS != prevDp) begin
      runLen = 1; prevIdx = idx; prevLit = litIn; prevDp = dpS;
    end else begin
      runLen++;
    end
    if (runLen == S) begin
      val = -1;
      for (int v = 0; v < 16; v++) if (segTable[v] == litIn) val = v;
      if (val >= 0) begin
        expNib[idx] = 4'(val); expValid[idx] = 1'b1; expUpd = 1'b1;
      end else begin
        expValid[idx] = 1'b0; expErr = (litIn != 7'h00);
      end
      expDp[idx] = dpS;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] segIn, input bit anodeIn, input logic [N-1:0] enIn,
                               input bit rstIn, input bit dpLitIn, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      seg = segIn; anode = anodeIn; en = enIn; rst = rstIn;
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
      dpIn = anodeIn ? ~dpLitIn : dpLitIn;
`endif
      @(posedge clk);
      modelEdge(anodeIn ? ~segIn : segIn, enIn, rstIn, dpLitIn);
      #1;
      checkOutput("nibbles", 32'(nibblesOut), 32'(packNibbles()));
      checkOutput("valid", 32'(validOut), 32'(packValid()));
      checkOutput("update", 32'(updateOut), 32'(expUpd));
      checkOutput("error", 32'(errorOut), 32'(expErr));
`ifdef SEVEN_SEGMENT_DECODER_DP_EN
      checkOutput("dpFlags", 32'(dpFlagsOut), 32'(packDp()));
`endif
      updSeen += int'(updateOut);
      errSeen += int'(errorOut);
    end
  endtask

  initial begin
    logic [6:0] litR;
    logic [N-1:0] enR;
    bit anR;
    int r;
    runLen = 0; prevIdx = 0; prevLit = 7'h00; prevDp = 1'b0;
    for (int k = 0; k < N; k++) begin
      expNib[k] = 4'h0; expValid[k] = 1'b0; expDp[k] = 1'b0;
    end

    applyStimulus(7'h00, 1'b0, 4'b0000, 1'b1, 1'b0, 2);
    checkOutput("resetNibbles", 32'(nibblesOut), 32'h0);
    checkOutput("resetValid", 32'(validOut), 32'h0);

    // Common anode 0x24 -> lit 5B -> 2
    applyStimulus(7'h24, 1'b1, 4'b0001, 1'b0, 1'b0, 4);
    checkOutput("t1Nibble0", 32'(nibblesOut[3:0]), 32'h2);
    checkOutput("t1Valid", 32'(validOut), 32'h1);
    applyStimulus(7'h24, 1'b1, 4'b0001, 1'b0, 1'b0, 3);
    checkOutput("t1Pulses", 32'(updSeen), 32'd1);

    applyStimulus(7'h06, 1'b0, 4'b0001, 1'b0, 1'b0, 4);
    applyStimulus(7'h4F, 1'b0, 4'b0010, 1'b0, 1'b0, 4);
    applyStimulus(7'h77, 1'b0, 4'b0100, 1'b0, 1'b0, 4);
    applyStimulus(7'h71, 1'b0, 4'b1000, 1'b0, 1'b0, 4);
    checkOutput("t2Nibbles", 32'(nibblesOut), 32'hFA31);
    checkOutput("t2Valid", 32'(validOut), 32'hF);
    checkOutput("t2Pulses", 32'(updSeen), 32'd5);

    // Interrupted run of 2, then a full run of 3
    applyStimulus(7'h24, 1'b1, 4'b0001, 1'b0, 1'b0, 3);
    applyStimulus(7'h30, 1'b1, 4'b0001, 1'b0, 1'b0, 4);
    checkOutput("t3Nibbles", 32'(nibblesOut), 32'hFA33);
    checkOutput("t3Pulses", 32'(updSeen), 32'd6);

    applyStimulus(7'h01, 1'b0, 4'b0010, 1'b0, 1'b0, 4);
    checkOutput("t4ErrPulses", 32'(errSeen), 32'd1);
    checkOutput("t4Valid", 32'(validOut), 32'hD);
    checkOutput("t4Nibble1", 32'(nibblesOut[7:4]), 32'h3);
    applyStimulus(7'h00, 1'b0, 4'b0010, 1'b0, 1'b0, 4);
    checkOutput("t4BlankErr", 32'(errSeen), 32'd1);
    checkOutput("t4BlankValid", 32'(validOut), 32'hD);

    applyStimulus(7'h7D, 1'b0, 4'b0100, 1'b0, 1'b0, 2);
    applyStimulus(7'h7D, 1'b0, 4'b0011, 1'b0, 1'b0, 1);
    applyStimulus(7'h7D, 1'b0, 4'b0100, 1'b0, 1'b0, 2);
    applyStimulus(7'h7D, 1'b0, 4'b0000, 1'b0, 1'b0, 1);
    applyStimulus(7'h7D, 1'b0, 4'b0100, 1'b0, 1'b0, 3);
    applyStimulus(7'h7D, 1'b0, 4'b0100, 1'b1, 1'b0, 1);
    checkOutput("t5Nibbles", 32'(nibblesOut), 32'h0);
    checkOutput("t5Valid", 32'(validOut), 32'h0);
    checkOutput("t5Pulses", 32'(updSeen), 32'd6);

`ifdef SEVEN_SEGMENT_DECODER_DP_EN
    applyStimulus(7'h7F, 1'b0, 4'b0100, 1'b0, 1'b1, 4);
    checkOutput("dpNibble2", 32'(nibblesOut[11:8]), 32'h8);
    checkOutput("dpFlagsDirect", 32'(dpFlagsOut), 32'h4);
`endif

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) enR = '0;
      else if (r == 1) enR = 4'b0011 << $urandom_range(0, 2);
      else enR = 4'b0001 << $urandom_range(0, N - 1);
      r = $urandom_range(0, 9);
      if (r == 0) litR = 7'h00;
      else if (r < 3) litR = 7'($urandom);
      else litR = segTable[$urandom_range(0, 15)];
      anR = 1'($urandom);
      applyStimulus(anR ? ~litR : litR, anR, enR, ($urandom_range(0, 49) == 0), 1'($urandom), $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Recovers hex digits from a multiplexed seven-segment display bus, the inverse of the board's 4-bit to seven-segment translator. It samples segment lines plus one-hot digit enables, waits until a segment pattern is stable, and then decodes it back to a nibble per digit. It sits on the observation side of display-driving logic: self-check of display paths on the board, and snooping of external scanned displays. Inputs are assumed already synchronized to i_CLK.

## Interface
- N_DIGITS, 4, number of scanned digit positions (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before commit (1..255)
- i_CLK  input  1  system clock, all logic on rising edge
- i_RESET  input  1  synchronous, active-high reset
- i_SEVEN_SEGMENT_NUMBER  input  7  segment lines, bit0 = a … bit6 = g
- i_COMMON_ANOD  input  1  1: segment bit 0 = lit (common anode); 0: segment bit 1 = lit
- i_DIGIT_ENABLE  input  N_DIGITS  one-hot active-high digit select
- o_FOUR_BIT_NUMBERS  output  4*N_DIGITS  decoded nibble per digit, digit k at [4k+3:4k]
- o_DIGIT_VALID  output  N_DIGITS  digit k holds a legal decoded value
- o_UPDATE  output  1  one-cycle pulse on every legal commit
- o_ERROR  output  1  one-cycle pulse on commit of an illegal pattern

## Operation
- Normalize every cycle: lit = i_COMMON_ANOD ? ~i_SEVEN_SEGMENT_NUMBER : i_SEVEN_SEGMENT_NUMBER.
- Sample = {digit index, lit}. It is valid only when i_DIGIT_ENABLE has exactly one bit set. Zero or multiple bits set → IDLE.
- States:
  - IDLE: no valid sample; run counter = 0.
  - TRACK: run counter counting identical samples.
  - HELD: already committed; waits for the sample to change.
- Transitions:
  - Valid sample that differs from the stored sample (or any valid sample from IDLE) → store it, counter = 1, TRACK.
  - Identical sample → counter increments.
  - Counter reaching STABLE_CYCLES → commit, HELD.
  - HELD + identical sample → stay in HELD, no further commits.
  - Invalid enable in any state → IDLE.
- Decode table, lit form in hex, value 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Commit results:
  - Table match: write the nibble to the digit, set its valid bit, pulse o_UPDATE.
  - lit = 00 (blank): clear the valid bit, keep the nibble, no pulse.
  - Any other pattern: clear the valid bit, keep the nibble, pulse o_ERROR.
- Switching i_COMMON_ANOD alone changes lit, which counts as a new sample.

## Timing
- Reset values: o_FOUR_BIT_NUMBERS = 0, o_DIGIT_VALID = 0, o_UPDATE = 0, o_ERROR = 0, state IDLE, counter 0.
- All outputs are registered. A sample first seen at edge t commits at edge t+STABLE_CYCLES-1, and outputs are visible after that edge.
- STABLE_CYCLES = 1 commits at the first edge a new sample is seen.
- o_UPDATE and o_ERROR are high for exactly one cycle per commit and are never asserted together.
- A sample change on the commit edge means no commit; the counter restarts at 1.
- i_RESET has priority over everything. Reset mid-run discards the run and clears all digits.
- Counter is 8 bits and cannot exceed STABLE_CYCLES, so there is no wrap.

## Configuration
- SEVEN_SEGMENT_DECODER_DP_EN defined:
  - Adds input i_DECIMAL_POINT (1 bit, same polarity as segments) and output o_DP_FLAGS (N_DIGITS).
  - DP is part of the stability compare.
  - On any commit, o_DP_FLAGS[k] is written with the normalized DP value, including blank and illegal patterns.
  - Resets to 0.
- SEVEN_SEGMENT_DECODER_DP_EN undefined: neither port exists, and only 7 segment bits are compared.

## Test plan
- Reset, then i_COMMON_ANOD = 1, enable = 0001, segments = 0x24 for 4 cycles → o_FOUR_BIT_NUMBERS[3:0] = 2, o_DIGIT_VALID = 0001, one o_UPDATE pulse at the 4th edge, none afterwards.
- i_COMMON_ANOD = 0, scan digits 0..3 with lit 06, 4F, 77, 71, each held 4 cycles → o_FOUR_BIT_NUMBERS = 0xFA31, valid = 1111, four o_UPDATE pulses.
- Segments = 0x24 for 3 cycles, then 0x30 for 4 cycles (anode) → no commit of 2; nibble = 3 at the 7th edge.
- Lit = 0x01 held 4 cycles on digit 1 → o_ERROR single pulse, valid[1] = 0, nibble unchanged; then lit = 0x00 → valid stays 0, no pulse.
- Enable = 0011 or 0000 mid-run → IDLE, no commit. i_RESET asserted on the commit edge → all outputs 0 and no pulse.
- With SEVEN_SEGMENT_DECODER_DP_EN defined: lit 7F with DP lit on digit 2 → nibble 8, o_DP_FLAGS = 0100.
